// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, default sizes and
// the settle-counter width helper.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_OP_W        = 3;
    localparam int DEF_EXEC_CYCLES = 1;

    // Width of a counter that must reach exec_cycles; never narrower than one bit.
    function automatic int cnt_width(input int exec_cycles);
        if (exec_cycles < 1) begin
            return 1;
        end else begin
            return $clog2(exec_cycles + 1);
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester wins outright;
// on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       id
);

    // Select the winner from the request pair and the previous grant.
    always_comb begin
        valid = |req;
        id    = 1'b0;
        case (req)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = ~last_grant;
            default: id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. The winner's operands are registered
// onto the ALU inputs, held for EXEC_CYCLES, then the ALU result and flags are
// captured and a one-cycle done pulse goes to the granted requester.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int OP_W        = DEF_OP_W,
    parameter int EXEC_CYCLES = DEF_EXEC_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [OP_W-1:0]  op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OP_W-1:0]  op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy,
    output logic             gnt_id,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    localparam int               CNT_W    = cnt_width(EXEC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES);

    // A zero settle time would capture before the ALU inputs are even valid.
    if (EXEC_CYCLES < 1) begin : g_bad_exec_cycles
        $error("alu_arbiter: EXEC_CYCLES must be >= 1");
    end

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             last_grant_r, last_grant_n;
    logic             gnt_id_r, gnt_id_n;
    logic [WIDTH-1:0] alu_a_r, alu_a_n;
    logic [WIDTH-1:0] alu_b_r, alu_b_n;
    logic [OP_W-1:0]  alu_op_r, alu_op_n;
    logic [WIDTH-1:0] res_r, res_n;
    logic             zero_r, zero_n;
    logic             ovf_r, ovf_n;
    logic [1:0]       done_r, done_n;
    logic             busy_r, busy_n;
    logic             pick_valid_s;
    logic             pick_id_s;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .id         (pick_id_s)
    );

    // Next-state and next-output logic for the grant / settle / complete cycle.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        last_grant_n = last_grant_r;
        gnt_id_n     = gnt_id_r;
        alu_a_n      = alu_a_r;
        alu_b_n      = alu_b_r;
        alu_op_n     = alu_op_r;
        res_n        = res_r;
        zero_n       = zero_r;
        ovf_n        = ovf_r;
        done_n       = 2'b00;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_id_n     = pick_id_s;
                    last_grant_n = pick_id_s;
                    if (pick_id_s) begin
                        alu_op_n = op1;
                        alu_a_n  = a1;
                        alu_b_n  = b1;
                    end else begin
                        alu_op_n = op0;
                        alu_a_n  = a0;
                        alu_b_n  = b0;
                    end
                    cnt_n   = CNT_ONE;
                    state_n = EXEC;
                end else begin
                    state_n = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_LAST) begin
                    res_n   = alu_res;
                    zero_n  = alu_zero;
                    ovf_n   = alu_overflow;
                    done_n  = gnt_id_r ? 2'b10 : 2'b01;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            last_grant_r <= 1'b1;
            gnt_id_r     <= 1'b0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_op_r     <= '0;
            res_r        <= '0;
            zero_r       <= 1'b0;
            ovf_r        <= 1'b0;
            done_r       <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            last_grant_r <= last_grant_n;
            gnt_id_r     <= gnt_id_n;
            alu_a_r      <= alu_a_n;
            alu_b_r      <= alu_b_n;
            alu_op_r     <= alu_op_n;
            res_r        <= res_n;
            zero_r       <= zero_n;
            ovf_r        <= ovf_n;
            done_r       <= done_n;
            busy_r       <= busy_n;
        end
    end

    assign done       = done_r;
    assign res_o      = res_r;
    assign zero_o     = zero_r;
    assign overflow_o = ovf_r;
    assign busy       = busy_r;
    assign gnt_id     = gnt_id_r;
    assign alu_A      = alu_a_r;
    assign alu_B      = alu_b_r;
    assign alu_op     = alu_op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: one instance with a one-cycle settle time and one
// with three, each driving an adder stub ALU.
module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Instance A: EXEC_CYCLES = 1
    logic [1:0]  a_req;
    logic [2:0]  a_op0, a_op1;
    logic [31:0] a_a0, a_b0, a_a1, a_b1;
    logic [1:0]  a_done;
    logic [31:0] a_res;
    logic        a_zero, a_ovf, a_busy, a_gnt;
    logic [31:0] a_alu_A, a_alu_B, a_alu_res;
    logic [2:0]  a_alu_op;
    logic        a_alu_zero, a_alu_ovf, a_force_ovf;

    // Instance C: EXEC_CYCLES = 3
    logic [1:0]  c_req;
    logic [2:0]  c_op0, c_op1;
    logic [31:0] c_a0, c_b0, c_a1, c_b1;
    logic [1:0]  c_done;
    logic [31:0] c_res;
    logic        c_zero, c_ovf, c_busy, c_gnt;
    logic [31:0] c_alu_A, c_alu_B, c_alu_res;
    logic [2:0]  c_alu_op;
    logic        c_alu_zero, c_alu_ovf;

    assign a_alu_res  = a_alu_A + a_alu_B;
    assign a_alu_zero = (a_alu_res == 32'd0);
    assign a_alu_ovf  = a_force_ovf;
    assign c_alu_res  = c_alu_A + c_alu_B;
    assign c_alu_zero = (c_alu_res == 32'd0);
    assign c_alu_ovf  = 1'b0;

    alu_arbiter #(.WIDTH(32), .OP_W(3), .EXEC_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(a_req),
        .op0(a_op0), .a0(a_a0), .b0(a_b0), .op1(a_op1), .a1(a_a1), .b1(a_b1),
        .done(a_done), .res_o(a_res), .zero_o(a_zero), .overflow_o(a_ovf),
        .busy(a_busy), .gnt_id(a_gnt), .alu_A(a_alu_A), .alu_B(a_alu_B),
        .alu_op(a_alu_op), .alu_res(a_alu_res), .alu_zero(a_alu_zero),
        .alu_overflow(a_alu_ovf)
    );

    alu_arbiter #(.WIDTH(32), .OP_W(3), .EXEC_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .req(c_req),
        .op0(c_op0), .a0(c_a0), .b0(c_b0), .op1(c_op1), .a1(c_a1), .b1(c_b1),
        .done(c_done), .res_o(c_res), .zero_o(c_zero), .overflow_o(c_ovf),
        .busy(c_busy), .gnt_id(c_gnt), .alu_A(c_alu_A), .alu_B(c_alu_B),
        .alu_op(c_alu_op), .alu_res(c_alu_res), .alu_zero(c_alu_zero),
        .alu_overflow(c_alu_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a done pulse on instance A; returns the cycle stamp.
    task automatic wait_done(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_done != 2'b00) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Scoreboard: every done pulse on instance A pops and checks one expectation.
    always @(negedge clk) begin
        if (!rst && a_done != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'd0, a_done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_done", {30'd0, a_done}, {30'd0, mon_e.done});
                chk("sb_res",  a_res, mon_e.res);
                chk("sb_zero", {31'd0, a_zero}, {31'd0, mon_e.zero});
                chk("sb_ovf",  {31'd0, a_ovf},  {31'd0, mon_e.ovf});
            end
        end
    end

    initial begin
        int t, prev;
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        a_req = 2'b00; a_op0 = 3'd0; a_a0 = 32'd0; a_b0 = 32'd0;
        a_op1 = 3'd0; a_a1 = 32'd0; a_b1 = 32'd0; a_force_ovf = 1'b0;
        c_req = 2'b00; c_op0 = 3'd0; c_a0 = 32'd0; c_b0 = 32'd0;
        c_op1 = 3'd0; c_a1 = 32'd0; c_b1 = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_done", {30'd0, a_done}, 32'd0);
        chk("rst_res", a_res, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_aluA", a_alu_A, 32'd0);
        chk("rst_aluop", {29'd0, a_alu_op}, 32'd0);
        rst = 1'b0;

        // Single request from requester 0: 31 + 8
        @(negedge clk);
        a_req = 2'b01; a_op0 = 3'd2; a_a0 = 32'd31; a_b0 = 32'd8;
        sb.push_back('{2'b01, 32'd39, 1'b0, 1'b0});
        @(negedge clk);
        chk("t1_aluop", {29'd0, a_alu_op}, 32'd2);
        chk("t1_aluA", a_alu_A, 32'd31);
        chk("t1_aluB", a_alu_B, 32'd8);
        chk("t1_busy", {31'd0, a_busy}, 32'd1);
        chk("t1_nodone_yet", {30'd0, a_done}, 32'd0);
        @(negedge clk);
        chk("t1_done", {30'd0, a_done}, 32'd1);
        chk("t1_res", a_res, 32'd39);
        chk("t1_gnt", {31'd0, a_gnt}, 32'd0);
        a_req = 2'b00;

        // Requester 1 alone: 5 + (-5) gives zero
        @(negedge clk);
        a_req = 2'b10; a_op1 = 3'd5; a_a1 = 32'd5; a_b1 = 32'hFFFF_FFFB;
        sb.push_back('{2'b10, 32'd0, 1'b1, 1'b0});
        wait_done("t3", t);
        chk("t3_gnt", {31'd0, a_gnt}, 32'd1);
        chk("t3_zero", {31'd0, a_zero}, 32'd1);
        a_req = 2'b00;

        // Both requesting continuously: strict alternation starting with 0
        @(negedge clk);
        a_req = 2'b11; a_a0 = 32'd1; a_b0 = 32'd0; a_a1 = 32'd2; a_b1 = 32'd0;
        sb.push_back('{2'b01, 32'd1, 1'b0, 1'b0});
        sb.push_back('{2'b10, 32'd2, 1'b0, 1'b0});
        sb.push_back('{2'b01, 32'd1, 1'b0, 1'b0});
        sb.push_back('{2'b10, 32'd2, 1'b0, 1'b0});
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done("t2", t);
            if (i > 0) chk("t2_spacing", t - prev, 32'd3);
            prev = t;
        end
        a_req = 2'b00;

        // Overflow flag captured and held through idle cycles
        @(negedge clk);
        a_force_ovf = 1'b1; a_req = 2'b01; a_a0 = 32'd7; a_b0 = 32'd1;
        sb.push_back('{2'b01, 32'd8, 1'b0, 1'b1});
        wait_done("t6", t);
        a_req = 2'b00; a_force_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_ovf_held", {31'd0, a_ovf}, 32'd1);
        chk("t6_res_held", a_res, 32'd8);
        chk("t6_idle", {31'd0, a_busy}, 32'd0);
        a_req = 2'b10; a_a1 = 32'd3; a_b1 = 32'd4;
        sb.push_back('{2'b10, 32'd7, 1'b0, 1'b0});
        wait_done("t6b", t);
        chk("t6_ovf_clear", {31'd0, a_ovf}, 32'd0);
        a_req = 2'b00;

        // Reset during EXEC: operation lost, no done
        @(negedge clk);
        a_req = 2'b01; a_a0 = 32'd50; a_b0 = 32'd50;
        @(negedge clk);
        chk("t5_busy_pre", {31'd0, a_busy}, 32'd1);
        rst = 1'b1; a_req = 2'b00;
        #1;
        chk("t5_done", {30'd0, a_done}, 32'd0);
        chk("t5_busy", {31'd0, a_busy}, 32'd0);
        chk("t5_aluA", a_alu_A, 32'd0);
        chk("t5_res", a_res, 32'd0);
        chk("t5_ovf", {31'd0, a_ovf}, 32'd0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_done", {30'd0, a_done}, 32'd0);
        a_req = 2'b11; a_a0 = 32'd100; a_b0 = 32'd0; a_a1 = 32'd200; a_b1 = 32'd0;
        sb.push_back('{2'b01, 32'd100, 1'b0, 1'b0});
        wait_done("t5b", t);
        chk("t5_gnt0", {31'd0, a_gnt}, 32'd0);
        a_req = 2'b00;

        // EXEC_CYCLES = 3: operands altered during EXEC are ignored
        @(negedge clk);
        c_req = 2'b01; c_op0 = 3'd1; c_a0 = 32'd10; c_b0 = 32'd3;
        @(negedge clk);
        chk("t4_aluA0", c_alu_A, 32'd10);
        chk("t4_aluop", {29'd0, c_alu_op}, 32'd1);
        chk("t4_busy", {31'd0, c_busy}, 32'd1);
        chk("t4_gnt", {31'd0, c_gnt}, 32'd0);
        c_a0 = 32'd99;
        @(negedge clk);
        chk("t4_aluA1", c_alu_A, 32'd10);
        chk("t4_nodone1", {30'd0, c_done}, 32'd0);
        @(negedge clk);
        chk("t4_aluA2", c_alu_A, 32'd10);
        chk("t4_nodone2", {30'd0, c_done}, 32'd0);
        @(negedge clk);
        chk("t4_done", {30'd0, c_done}, 32'd1);
        chk("t4_res", c_res, 32'd13);
        chk("t4_zero", {31'd0, c_zero}, 32'd0);
        chk("t4_ovf", {31'd0, c_ovf}, 32'd0);
        c_req = 2'b00;
        @(negedge clk);
        chk("t4_done_once", {30'd0, c_done}, 32'd0);
        @(negedge clk);
        chk("t4_idle", {31'd0, c_busy}, 32'd0);
        chk("t4_aluA_hold", c_alu_A, 32'd10);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
